// File: rtl/lsu_mem.sv
// Load/store unit with integrated word-organised data memory, multi-cycle latency and req/ready handshake.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses and suppress their effect.
module lsu_mem #(
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mis_q, mis_d;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic                is_byte, is_half;
  logic                access_now;
  logic                mis_acc;
  logic                mem_we;
  logic [3:0]          be;
  logic [31:0]         wr_word;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         ld_val;

  // Address bits above the memory window are intentionally ignored (index wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  assign word_idx   = addr_q[ADDR_W+1:2];
  assign lane       = addr_q[1:0];
  assign is_byte    = (size_q == 2'b00);
  assign is_half    = (size_q == 2'b01);
  assign access_now = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_acc = is_half ? addr_q[0] : (!is_byte && (addr_q[1:0] != 2'b00));
`else
  assign mis_acc = 1'b0;
`endif

  // Store lane steering: replicate the right-justified data, let byte enables pick the lane.
  always_comb begin
    be      = 4'b1111;
    wr_word = wdata_q;
    if (is_byte) begin
      be      = 4'b0001 << lane;
      wr_word = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      be      = addr_q[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[7:0];
    case (lane)
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    if (is_byte)
      ld_val = sext_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
    else if (is_half)
      ld_val = sext_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
    else
      ld_val = rd_word;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = addr[ADDR_W+1:0];
          wdata_d = wdata;
          cnt_d   = 4'(LATENCY - 1);
          mis_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!access_now) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mis_d   = mis_acc;
          state_d = DONE;
          if (we_q)
            mem_we = !mis_acc;
          else
            rdata_d = mis_acc ? 32'd0 : ld_val;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Memory is not reset; a reset forces IDLE so no write can commit afterwards.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign rdata    = rdata_q;
  assign ready    = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign misalign = (state_q == DONE) && mis_q;

endmodule
